// File: rtl/pixel_stream_unpacker.sv
// pixel_stream_unpacker
// Receives full result words from the brightness processor, which cannot be
// stalled, buffers them in a small word FIFO, and serialises each word into
// one color sample per valid/ready transfer for a stallable consumer.
// Lane 0 (the least significant COLOR_SIZE bits) of each word is sent first.
// A word that arrives while the FIFO is full and not popping on that edge is
// dropped, and the sticky overflow flag records the loss.

module pixel_stream_unpacker #(
  parameter int DATA_WIDTH = 32,  // 32 or 64, multiple of COLOR_SIZE
  parameter int COLOR_SIZE = 8,
  parameter int FIFO_DEPTH = 4    // power of two, >= 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_rdy,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [COLOR_SIZE-1:0]         out_color,
  output logic                          out_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          busy
);

  localparam int LANES  = DATA_WIDTH / COLOR_SIZE;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [CW-1:0]     FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  // Word storage. Data is never reset; only the pointers and count are.
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          ovf_q,    ovf_d;

  // Serialiser state. The shift register presents the current lane in its
  // low COLOR_SIZE bits and shifts right as lanes are accepted.
  state_t                state_q;
  logic [DATA_WIDTH-1:0] sr_q;
  logic [LANE_W-1:0]     lane_q;
  logic                  valid_q;

  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  xfer;
  logic                  on_last_lane;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic [DATA_WIDTH-1:0] head;

  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == FULL_CNT);
  assign xfer         = valid_q & out_ready;
  assign on_last_lane = (lane_q == LAST_LANE);
  assign head         = mem_q[rd_ptr_q];

  // A pop happens either to fill an idle serialiser or, with no bubble, on
  // the edge that accepts the final lane of the word being sent.
  assign pop = ~fifo_empty &
               ((state_q == S_IDLE) |
                ((state_q == S_SEND) & xfer & on_last_lane));

  // A full FIFO still accepts a word when a pop frees a slot on the same
  // edge; the read uses the old head because the write is non-blocking.
  assign push = in_rdy & (~fifo_full | pop);
  assign drop = in_rdy & fifo_full & ~pop;

  // FIFO pointer, occupancy and overflow next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // FIFO control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Word storage write port.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Serialiser FSM: loads words from the FIFO head and steps through lanes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      lane_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            sr_q    <= head;
            lane_q  <= '0;
            valid_q <= 1'b1;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          if (xfer) begin
            if (!on_last_lane) begin
              sr_q   <= sr_q >> COLOR_SIZE;
              lane_q <= lane_q + LANE_W'(1);
            end else if (!fifo_empty) begin
              sr_q   <= head;
              lane_q <= '0;
            end else begin
              valid_q <= 1'b0;
              lane_q  <= '0;
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          lane_q  <= '0;
        end
      endcase
    end
  end

  assign out_valid  = valid_q;
  assign out_color  = sr_q[COLOR_SIZE-1:0];
  assign out_last   = valid_q & on_last_lane;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign busy       = ~fifo_empty | valid_q;

endmodule

// File: doc/pixel_stream_unpacker.md
Name: pixel_stream_unpacker

Overview:
- Sits downstream of the brightness processor and is the receive end of its word interface.
- Captures each DATA_WIDTH-bit result word on its ready strobe and buffers it in a small word FIFO.
- Serialises buffered words into one color sample per transfer on a valid/ready stream for the writeback/output path.
- Provides buffering plus a rate break between the non-backpressurable processor output and a stallable consumer.

Parameters:
- DATA_WIDTH, 32: word width; must be 32 or 64 and a multiple of COLOR_SIZE.
- COLOR_SIZE, `COLOR_SIZE (8): bits per color sample. LANES = DATA_WIDTH/COLOR_SIZE.
- FIFO_DEPTH, 4: word FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_rdy  in  1  word strobe, driven by the processor's data_out_rdy; one word per cycle high.
- in_data  in  DATA_WIDTH  word, driven by the processor's data_out; sampled when in_rdy=1.
- out_ready  in  1  consumer accepts the current sample.
- out_valid  out  1  out_color is valid.
- out_color  out  COLOR_SIZE  current color sample.
- out_last  out  1  current sample is the final lane of its word.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words held in the FIFO; excludes the serialiser register.
- overflow  out  1  sticky flag: a word was dropped.
- busy  out  1  FIFO non-empty or serialiser holding a word.

Behaviour:
- Reset: rst=1 at a clock edge clears the FIFO pointers and count, the serialiser, and the lane counter. All outputs go to 0 on that edge.
- Reset mid-operation discards every buffered and partially sent word and clears overflow.
- Transfer: a sample is accepted on any edge where out_valid=1 and out_ready=1.
- While out_valid=1 and out_ready=0, out_color and out_last hold stable.
- out_valid never drops without an accepted transfer, except on reset.
- Input side: an in_rdy=1 edge writes in_data to the FIFO when not full.
- If the FIFO is full and no pop occurs on the same edge, the word is dropped and overflow is set. overflow stays set until reset.
- A push and a pop on the same edge while full are both performed; count is unchanged and no overflow.
- A push on an empty FIFO with no pop gives fifo_count=1 after the edge.
- Serialiser FSM:
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, lane=0, out_valid=1, go to SEND.
  - SEND, transfer with lane<LANES-1: lane+1; present the next lane.
  - SEND, transfer with lane=LANES-1 (out_last=1), FIFO non-empty: pop and load the next word on the same edge, lane=0, stay in SEND. There is no bubble between words.
  - SEND, transfer with lane=LANES-1, FIFO empty: out_valid=0, go to IDLE.
- Lane order: lane i maps to in_data[i*COLOR_SIZE +: COLOR_SIZE]; lane 0 is sent first.
- out_last = (lane == LANES-1) & out_valid.
- Latency: in_rdy high in cycle k with the FIFO empty and the FSM idle puts the word in the FIFO at edge k. Pop at edge k+1 gives out_valid=1 in cycle k+2.
- Capacity before drop: FIFO_DEPTH words in the FIFO plus 1 word in the serialiser.
- busy = (fifo_count != 0) | out_valid.
- No combinational path from in_rdy/in_data to any output.

Test Plan:
1. Single word, DATA_WIDTH=32: in_rdy=1 with in_data=0x44332211, out_ready=1.
   -> out_valid rises 2 cycles later.
   -> out_color 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles; out_last=1 only with 0x44; then out_valid=0, busy=0.
2. Backpressure: send word 0xDDCCBBAA; drop out_ready for 3 cycles after the first transfer.
   -> out_color holds 0xBB with out_valid=1 for those 3 cycles.
   -> Sequence completes AA, BB, CC, DD with no loss or duplication.
3. Back-to-back: 4 consecutive in_rdy words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; out_ready=1.
   -> 16 samples 0x00..0x0F on 16 consecutive cycles, no gap at word boundaries; overflow=0.
4. Overflow, FIFO_DEPTH=4: out_ready=0; 6 consecutive in_rdy words W0..W5.
   -> fifo_count=4, overflow=1, W5 dropped.
   -> Then out_ready=1 yields exactly the 20 samples of W0..W4; overflow stays 1.
5. Full push/pop: FIFO full (count=4) with the serialiser on its last lane; in_rdy=1 and out_ready=1 on the same edge.
   -> New word accepted, fifo_count stays 4, overflow=0, next word starts the following cycle.
6. Reset mid-word: assert rst for 1 cycle after 2 of 4 samples are sent, with 3 words queued.
   -> After the edge: out_valid=0, fifo_count=0, overflow=0, busy=0.
   -> A fresh word 0x87654321 afterwards emits 0x21, 0x43, 0x65, 0x87.
